spi_arbiter: RTL and testbench

- Shares the single SPI engine (start/busy/width_16/data_tx/data_rx) between two requesters, e.g. the CPU peripheral port and a display refresh engine.
- Arbitrates round-robin and owns the SPI start/busy handshake.
- Drives one active-low chip select per requester, with programmable setup/hold.
- Returns received data plus a done or error pulse to the winning requester.

---
 rtl/spi_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_spi_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI engine between two requesters.
// Owns the start/busy handshake, the per-requester chip selects and result return.
module spi_arbiter #(
  parameter int unsigned CS_SETUP      = 2,
  parameter int unsigned CS_HOLD       = 1,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic        raw_clk,
  input  logic        reset,

  input  logic        req_0,
  input  logic        req_1,
  input  logic        width_16_0,
  input  logic        width_16_1,
  input  logic [15:0] data_tx_0,
  input  logic [15:0] data_tx_1,
  output logic        done_0,
  output logic        done_1,
  output logic        error_0,
  output logic        error_1,
  output logic [7:0]  data_rx_0,
  output logic [7:0]  data_rx_1,
  output logic        cs_0,
  output logic        cs_1,

  output logic        spi_start,
  output logic        spi_width_16,
  output logic [15:0] spi_data_tx,
  input  logic [7:0]  spi_data_rx,
  input  logic        spi_busy,

  output logic        active,
  output logic        owner
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    XFER,
    HOLD,
    DONE
  } state_t;

  // Terminal counts; a zero-length phase is skipped outright, so its value is unused.
  localparam logic [7:0] SETUP_LAST   = 8'((CS_SETUP == 0) ? 0 : CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST    = 8'((CS_HOLD == 0) ? 0 : CS_HOLD - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'((START_TIMEOUT == 0) ? 0 : START_TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       aborted;

  logic       grant_valid;
  logic       grantee;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid = req_0 | req_1;
    grantee     = req_1;
    if (req_0 && req_1) begin
      grantee = ~owner;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      aborted      <= 1'b0;
      cs_0         <= 1'b1;
      cs_1         <= 1'b1;
      spi_start    <= 1'b0;
      spi_width_16 <= 1'b0;
      spi_data_tx  <= 16'd0;
      done_0       <= 1'b0;
      done_1       <= 1'b0;
      error_0      <= 1'b0;
      error_1      <= 1'b0;
      data_rx_0    <= 8'd0;
      data_rx_1    <= 8'd0;
      active       <= 1'b0;
      owner        <= 1'b1;
    end else begin
      done_0  <= 1'b0;
      done_1  <= 1'b0;
      error_0 <= 1'b0;
      error_1 <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner        <= grantee;
            spi_width_16 <= grantee ? width_16_1 : width_16_0;
            spi_data_tx  <= grantee ? data_tx_1 : data_tx_0;
            if (grantee) begin
              cs_1 <= 1'b0;
            end else begin
              cs_0 <= 1'b0;
            end
            active  <= 1'b1;
            aborted <= 1'b0;
            cnt     <= 8'd0;
            if (CS_SETUP == 0) begin
              spi_start <= 1'b1;
              state     <= START;
            end else begin
              state <= SETUP;
            end
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt       <= 8'd0;
            spi_start <= 1'b1;
            state     <= START;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        START: begin
          if (spi_busy) begin
            spi_start <= 1'b0;
            state     <= XFER;
          end else if (cnt == TIMEOUT_LAST) begin
            // Engine never acknowledged: release the device and report an error.
            spi_start <= 1'b0;
            cs_0      <= 1'b1;
            cs_1      <= 1'b1;
            aborted   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        XFER: begin
          if (!spi_busy) begin
            if (owner) begin
              data_rx_1 <= spi_data_rx;
            end else begin
              data_rx_0 <= spi_data_rx;
            end
            cnt <= 8'd0;
            if (CS_HOLD == 0) begin
              state <= DONE;
            end else begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DONE: begin
          cs_0   <= 1'b1;
          cs_1   <= 1'b1;
          active <= 1'b0;
          if (aborted) begin
            error_0 <= ~owner;
            error_1 <= owner;
          end else begin
            done_0 <= ~owner;
            done_1 <= owner;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a simple SPI engine model plus a second
// instance with zero setup/hold driven by hand.
module tb_spi_arbiter;

  logic        raw_clk;
  logic        reset;

  logic        req_0, req_1, width_16_0, width_16_1;
  logic [15:0] data_tx_0, data_tx_1;
  logic        done_0, done_1, error_0, error_1;
  logic [7:0]  data_rx_0, data_rx_1;
  logic        cs_0, cs_1;
  logic        spi_start, spi_width_16;
  logic [15:0] spi_data_tx;
  logic [7:0]  spi_data_rx;
  logic        spi_busy;
  logic        active, owner;

  logic        p_req_0, p_req_1, p_width_16_0, p_width_16_1;
  logic [15:0] p_data_tx_0, p_data_tx_1;
  logic        p_done_0, p_done_1, p_error_0, p_error_1;
  logic [7:0]  p_data_rx_0, p_data_rx_1;
  logic        p_cs_0, p_cs_1;
  logic        p_spi_start, p_spi_width_16;
  logic [15:0] p_spi_data_tx;
  logic [7:0]  p_spi_data_rx;
  logic        p_spi_busy;
  logic        p_active, p_owner;

  int n_vec = 0;
  int n_bad = 0;

  bit       engine_en = 1'b1;
  int       busy_len  = 4;
  bit       both_low  = 1'b0;
  bit       both_pulse = 1'b0;
  bit       grants[$];
  bit       exp_grants [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  spi_arbiter #(.CS_SETUP(2), .CS_HOLD(1), .START_TIMEOUT(15)) dut (
    .raw_clk(raw_clk), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .width_16_0(width_16_0), .width_16_1(width_16_1),
    .data_tx_0(data_tx_0), .data_tx_1(data_tx_1),
    .done_0(done_0), .done_1(done_1),
    .error_0(error_0), .error_1(error_1),
    .data_rx_0(data_rx_0), .data_rx_1(data_rx_1),
    .cs_0(cs_0), .cs_1(cs_1),
    .spi_start(spi_start), .spi_width_16(spi_width_16),
    .spi_data_tx(spi_data_tx), .spi_data_rx(spi_data_rx),
    .spi_busy(spi_busy), .active(active), .owner(owner)
  );

  spi_arbiter #(.CS_SETUP(0), .CS_HOLD(0), .START_TIMEOUT(15)) dut_p (
    .raw_clk(raw_clk), .reset(reset),
    .req_0(p_req_0), .req_1(p_req_1),
    .width_16_0(p_width_16_0), .width_16_1(p_width_16_1),
    .data_tx_0(p_data_tx_0), .data_tx_1(p_data_tx_1),
    .done_0(p_done_0), .done_1(p_done_1),
    .error_0(p_error_0), .error_1(p_error_1),
    .data_rx_0(p_data_rx_0), .data_rx_1(p_data_rx_1),
    .cs_0(p_cs_0), .cs_1(p_cs_1),
    .spi_start(p_spi_start), .spi_width_16(p_spi_width_16),
    .spi_data_tx(p_spi_data_tx), .spi_data_rx(p_spi_data_rx),
    .spi_busy(p_spi_busy), .active(p_active), .owner(p_owner)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge raw_clk);
  endtask

  task automatic run_xfer(input bit who, input logic [15:0] tx, input logic w,
                          output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    if (who) begin
      req_1 = 1'b1; data_tx_1 = tx; width_16_1 = w;
    end else begin
      req_0 = 1'b1; data_tx_0 = tx; width_16_0 = w;
    end
    for (int c = 0; c < 200 && !got_done && !got_err; c++) begin
      tick();
      if (who ? done_1 : done_0) got_done = 1'b1;
      if (who ? error_1 : error_0) got_err = 1'b1;
    end
    if (who) req_1 = 1'b0; else req_0 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200; c++) begin
      if (!active && !spi_busy) break;
      tick();
    end
    check(tag, {active, spi_busy}, 0);
  endtask

  // Engine model: answers a start with busy for busy_len cycles.
  initial begin
    spi_busy = 1'b0;
    forever begin
      @(negedge raw_clk);
      if (engine_en && spi_start && !spi_busy) begin
        spi_busy = 1'b1;
        repeat (busy_len) @(negedge raw_clk);
        spi_busy = 1'b0;
      end
    end
  end

  always @(negedge raw_clk) begin
    if (!cs_0 && !cs_1) both_low = 1'b1;
    if ((done_0 && error_0) || (done_1 && error_1)) both_pulse = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit d, e, prev0, prev1, gap_ok;
    int n_start, n_err, n_done, n_relow;

    reset = 1'b1;
    req_0 = 0; req_1 = 0; width_16_0 = 0; width_16_1 = 0;
    data_tx_0 = 0; data_tx_1 = 0; spi_data_rx = 0;
    p_req_0 = 0; p_req_1 = 0; p_width_16_0 = 0; p_width_16_1 = 0;
    p_data_tx_0 = 0; p_data_tx_1 = 0; p_spi_data_rx = 0; p_spi_busy = 0;
    #2 reset = 1'b0;
    repeat (2) tick();

    check("rst_cs0", cs_0, 1);
    check("rst_cs1", cs_1, 1);
    check("rst_owner", owner, 1);
    check("rst_active", active, 0);
    check("rst_start", spi_start, 0);
    check("rst_tx", spi_data_tx, 0);
    check("rst_rx0", data_rx_0, 0);
    reset = 1'b1;
    tick();

    // 1: single request, 16-bit, engine busy 4 cycles, rx 0xA5
    spi_data_rx = 8'hA5;
    busy_len = 4;
    req_0 = 1; data_tx_0 = 16'h1234; width_16_0 = 1;
    tick();
    check("t1_cs0_low", cs_0, 0);
    check("t1_cs1_high", cs_1, 1);
    check("t1_start_setup", spi_start, 0);
    check("t1_owner", owner, 0);
    data_tx_0 = 16'hFFFF; width_16_0 = 0;
    tick();
    check("t1_start_setup2", spi_start, 0);
    tick();
    check("t1_start", spi_start, 1);
    check("t1_tx", spi_data_tx, 16'h1234);
    check("t1_width", spi_width_16, 1);
    tick();
    check("t1_start_drop", spi_start, 0);
    repeat (3) tick();
    check("t1_rx_not_yet", data_rx_0, 0);
    tick();
    check("t1_rx", data_rx_0, 8'hA5);
    check("t1_cs0_hold", cs_0, 0);
    tick();
    check("t1_cs0_done_state", cs_0, 0);
    check("t1_no_early_done", done_0, 0);
    tick();
    check("t1_done", done_0, 1);
    check("t1_cs0_release", cs_0, 1);
    check("t1_idle", active, 0);
    check("t1_cs1_never", cs_1, 1);
    req_0 = 0;
    tick();
    check("t1_done_pulse", done_0, 0);
    wait_idle("t1_idle_end");

    // 2: both requesters hold req high from reset; expect 0,1,0,1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    spi_data_rx = 8'h3C;
    busy_len = 2;
    req_0 = 1; req_1 = 1; data_tx_0 = 16'h0001; data_tx_1 = 16'h0002;
    prev0 = 1; prev1 = 1; gap_ok = 1;
    for (int c = 0; c < 400 && grants.size() < 4; c++) begin
      tick();
      if (!cs_0 && prev0) begin
        grants.push_back(1'b0);
        if (!prev1) gap_ok = 0;
      end
      if (!cs_1 && prev1) begin
        grants.push_back(1'b1);
        if (!prev0) gap_ok = 0;
      end
      prev0 = cs_0; prev1 = cs_1;
    end
    check("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      check($sformatf("t2_grant%0d", i), grants[i], exp_grants[i]);
    end
    check("t2_owner", owner, 1);
    check("t2_cs_gap", gap_ok, 1);
    req_0 = 0; req_1 = 0;
    wait_idle("t2_idle");
    check("t2_rx0", data_rx_0, 8'h3C);

    // 3: engine never answers -> timeout after 15 start cycles
    engine_en = 0;
    spi_data_rx = 8'h77;
    req_0 = 1; data_tx_0 = 16'h00FF;
    n_start = 0; n_err = 0; n_done = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (spi_start) n_start++;
      if (done_0) n_done++;
      if (error_0) begin
        n_err++;
        req_0 = 0;
      end
    end
    check("t3_start_cycles", n_start, 15);
    check("t3_error_pulses", n_err, 1);
    check("t3_no_done", n_done, 0);
    check("t3_rx_kept", data_rx_0, 8'h3C);
    check("t3_cs0_high", cs_0, 1);
    engine_en = 1;
    spi_data_rx = 8'h5A;
    run_xfer(1'b0, 16'h0F0F, 1'b0, d, e);
    check("t3_next_done", d, 1);
    check("t3_next_err", e, 0);
    check("t3_next_rx", data_rx_0, 8'h5A);
    wait_idle("t3_idle");

    // 4: req_1 dropped mid-transfer; transfer still completes, no re-grant
    busy_len = 6;
    spi_data_rx = 8'hC3;
    req_1 = 1; data_tx_1 = 16'h0A0B; width_16_1 = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (spi_busy && !spi_start && active) break;
    end
    check("t4_in_xfer", spi_busy, 1);
    req_1 = 0;
    n_done = 0; n_relow = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_1) n_done++;
      else if (n_done > 0 && !cs_1) n_relow++;
    end
    check("t4_done", n_done, 1);
    check("t4_no_regrant", n_relow, 0);
    check("t4_rx1", data_rx_1, 8'hC3);
    check("t4_idle", active, 0);

    // 5: reset during XFER
    busy_len = 8;
    spi_data_rx = 8'hE1;
    req_0 = 1; data_tx_0 = 16'h1111;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (spi_busy && !spi_start && active) break;
    end
    check("t5_in_xfer", spi_busy, 1);
    #1 reset = 1'b0;
    #1;
    check("t5_async_cs0", cs_0, 1);
    check("t5_async_start", spi_start, 0);
    check("t5_async_active", active, 0);
    check("t5_async_owner", owner, 1);
    req_0 = 0;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done_0 || error_0) n_done++;
    end
    reset = 1'b1;
    for (int c = 0; c < 30 && spi_busy; c++) begin
      tick();
      if (done_0 || error_0) n_done++;
    end
    check("t5_no_pulse", n_done, 0);
    check("t5_engine_quiet", spi_busy, 0);
    req_0 = 1; req_1 = 1; data_tx_0 = 16'h2222;
    tick();
    check("t5_tie_cs0", cs_0, 0);
    check("t5_tie_cs1", cs_1, 1);
    check("t5_tie_owner", owner, 0);
    req_1 = 0;
    d = 0;
    for (int c = 0; c < 100 && !d; c++) begin
      tick();
      if (done_0) d = 1;
    end
    req_0 = 0;
    check("t5_done", d, 1);
    check("t5_rx", data_rx_0, 8'hE1);
    wait_idle("t5_idle");

    // 6: zero setup/hold instance, busy driven by hand
    p_spi_data_rx = 8'h96;
    p_req_0 = 1; p_data_tx_0 = 16'hBEEF; p_width_16_0 = 0;
    tick();
    check("t6_cs0_low", p_cs_0, 0);
    check("t6_start_now", p_spi_start, 1);
    check("t6_tx", p_spi_data_tx, 16'hBEEF);
    p_spi_busy = 1;
    tick();
    check("t6_start_drop", p_spi_start, 0);
    tick();
    p_spi_busy = 0;
    tick();
    check("t6_rx", p_data_rx_0, 8'h96);
    check("t6_cs0_done_state", p_cs_0, 0);
    check("t6_no_early_done", p_done_0, 0);
    tick();
    check("t6_done", p_done_0, 1);
    check("t6_cs0_release", p_cs_0, 1);
    p_req_0 = 0;
    tick();
    check("t6_done_pulse", p_done_0, 0);
    check("t6_idle", p_active, 0);

    check("cs_exclusive", both_low, 0);
    check("done_err_exclusive", both_pulse, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
